// File: rtl/spi_slave_regs.sv
// Mode-0 SPI register-access slave: oversampled in the clk domain, command/address/data
// protocol with address auto-increment over a byte-wide register file.
module spi_slave_regs #(
  parameter int          ADDR_W    = 6,
  parameter logic [7:0]  DEVICE_ID = 8'hAD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cmd_err,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [7:0] CMD_WR = 8'h0A;
  localparam logic [7:0] CMD_RD = 8'h0B;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WR, S_RD, S_IGNORE
  } state_t;

  state_t              state, state_n;
  logic [2:0]          sclk_sync;
  logic [1:0]          cs_sync, mosi_sync;
  logic                cs_s, sclk_rise, sclk_fall;
  logic                armed;
  logic [2:0]          bit_cnt;
  logic [7:0]          shift_in, shift_out, rx_byte;
  logic                byte_done, rd_mode, rd_started;
  logic [ADDR_W-1:0]   ptr, addr_in;
  logic [7:0]          regs [DEPTH];

  assign cs_s      = cs_sync[1];
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign rx_byte   = {shift_in[6:0], mosi_sync[1]};
  assign addr_in   = rx_byte[ADDR_W-1:0];

  // armed stays low after reset until cs_n is seen high, so a transfer already
  // in progress at reset release is ignored until a fresh cs_n falling edge.
  assign busy = armed & ~cs_s;
  assign miso = (state == S_RD) & shift_out[7];

  function automatic logic [7:0] reg_read(input logic [ADDR_W-1:0] a);
    return (a == '0) ? DEVICE_ID : regs[a];
  endfunction

  // The cs_n chain resets to 0 ("low"); armed gates it so that is not seen as a select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      armed     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sclk_sync <= {sclk_sync[1:0], sclk};
      cs_sync   <= {cs_sync[0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
      armed     <= armed | cs_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_n and no latch is inferred.
    state_n = state;
    case (state)
      S_IDLE:   if (armed && !cs_s) state_n = S_CMD;
      S_CMD:    if (byte_done)
                  state_n = (rx_byte == CMD_WR || rx_byte == CMD_RD) ? S_ADDR : S_IGNORE;
      S_ADDR:   if (byte_done) state_n = rd_mode ? S_RD : S_WR;
      default:  state_n = state;
    endcase
    if (cs_s) state_n = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      shift_in   <= '0;
      shift_out  <= '0;
      rd_mode    <= 1'b0;
      rd_started <= 1'b0;
      ptr        <= '0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cmd_err    <= 1'b0;
      // NOTE: the register file is reset explicitly because reads after reset must return 0x00.
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else begin
      wr_valid <= 1'b0;
      cmd_err  <= 1'b0;

      if (state == S_IDLE || cs_s) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        shift_in <= rx_byte;
      end

      // A byte completing in the same clk as cs_n deasserting is dropped.
      if (!cs_s) begin
        case (state)
          S_CMD: if (byte_done) begin
            rd_mode <= (rx_byte == CMD_RD);
            cmd_err <= (rx_byte != CMD_WR) && (rx_byte != CMD_RD);
          end
          S_ADDR: if (byte_done) begin
            rd_started <= 1'b0;
            if (rd_mode) begin
              shift_out <= reg_read(addr_in);
              ptr       <= addr_in + 1'b1;
            end else begin
              ptr       <= addr_in;
            end
          end
          S_WR: if (byte_done) begin
            if (ptr != '0) begin
              regs[ptr] <= rx_byte;
              wr_valid  <= 1'b1;
              wr_addr   <= ptr;
              wr_data   <= rx_byte;
            end
            ptr <= ptr + 1'b1;
          end
          S_RD: begin
            if (sclk_rise) rd_started <= 1'b1;
            // The falling edge right after the address byte must not shift out bit 7.
            if (sclk_fall && rd_started) begin
              if (bit_cnt == 3'd0) begin
                shift_out <= reg_read(ptr);
                ptr       <= ptr + 1'b1;
              end else begin
                shift_out <= {shift_out[6:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: bit-banged SPI master, write/cmd_err monitors,
// hand-computed expected register contents and pulse counts.
module tb_spi_slave_regs;

  localparam int ADDR_W = 6;
  localparam int HALF   = 8;   // SCLK half period in clk cycles (SCLK = clk/16)

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sclk = 1'b0;
  logic              cs_n = 1'b1;
  logic              mosi = 1'b0;
  logic              miso, wr_valid, cmd_err, busy;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  int vectors = 0;
  int miscompares = 0;

  int                wr_cnt = 0;
  int                err_cnt = 0;
  logic              miso_seen = 1'b0;
  logic [ADDR_W-1:0] wa_log [4];
  logic [7:0]        wd_log [4];

  spi_slave_regs #(.ADDR_W(ADDR_W), .DEVICE_ID(8'hAD)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_err(cmd_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (wr_valid) begin
      if (wr_cnt < 4) begin
        wa_log[wr_cnt] = wr_addr;
        wd_log[wr_cnt] = wr_data;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (cmd_err) err_cnt = err_cnt + 1;
    if (miso) miso_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_cnt    = 0;
    err_cnt   = 0;
    miso_seen = 1'b0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      wait_clk(HALF);
      rx[i] = miso;
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_end();
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(10);
  endtask

  // Full transaction of three or four bytes; returns the MISO byte seen per slot.
  task automatic xact(input logic [7:0] b0, b1, b2, b3, input int nbytes,
                      output logic [7:0] r0, r1, r2, r3);
    r3 = 8'h00;
    cs_begin();
    xfer_bits(b0, 8, r0);
    xfer_bits(b1, 8, r1);
    xfer_bits(b2, 8, r2);
    if (nbytes > 3) xfer_bits(b3, 8, r3);
    cs_end();
  endtask

  logic [7:0] r0, r1, r2, r3;

  initial begin
    wait_clk(3);
    check("rst_miso",     miso, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr",  wr_addr, 0);
    check("rst_wr_data",  wr_data, 0);
    check("rst_cmd_err",  cmd_err, 0);
    check("rst_busy",     busy, 0);
    rst = 1'b0;
    wait_clk(6);

    // Single write
    clear_mon();
    cs_begin();
    check("busy_during", busy, 1);
    xfer_bits(8'h0A, 8, r0);
    xfer_bits(8'h2D, 8, r1);
    xfer_bits(8'h02, 8, r2);
    cs_end();
    check("busy_after", busy, 0);
    check("sw_count", wr_cnt, 1);
    check("sw_addr",  wa_log[0], 8'h2D);
    check("sw_data",  wd_log[0], 8'h02);

    // Burst write then read back
    clear_mon();
    xact(8'h0A, 8'h1F, 8'h52, 8'hAA, 4, r0, r1, r2, r3);
    check("bw_count", wr_cnt, 2);
    check("bw_addr0", wa_log[0], 8'h1F);
    check("bw_data0", wd_log[0], 8'h52);
    check("bw_addr1", wa_log[1], 8'h20);
    check("bw_data1", wd_log[1], 8'hAA);
    xact(8'h0B, 8'h1F, 8'h00, 8'h00, 4, r0, r1, r2, r3);
    check("br_cmd_miso",  r0, 8'h00);
    check("br_addr_miso", r1, 8'h00);
    check("br_byte0", r2, 8'h52);
    check("br_byte1", r3, 8'hAA);
    xact(8'h0B, 8'h2D, 8'h00, 8'h00, 3, r0, r1, r2, r3);
    check("sw_readback", r2, 8'h02);

    // Top address, wrap to the ID, write to address 0 dropped
    xact(8'h0A, 8'h3F, 8'h5A, 8'h00, 3, r0, r1, r2, r3);
    xact(8'h0B, 8'h3F, 8'h00, 8'h00, 4, r0, r1, r2, r3);
    check("wrap_3f", r2, 8'h5A);
    check("wrap_id", r3, 8'hAD);
    clear_mon();
    xact(8'h0A, 8'h00, 8'h77, 8'h00, 3, r0, r1, r2, r3);
    check("a0_no_wr", wr_cnt, 0);
    xact(8'h0B, 8'h40, 8'h00, 8'h00, 3, r0, r1, r2, r3);
    check("id_upper_dropped", r2, 8'hAD);

    // Bad command
    clear_mon();
    xact(8'h55, 8'h10, 8'h77, 8'h00, 3, r0, r1, r2, r3);
    check("bad_cmd_err", err_cnt, 1);
    check("bad_no_wr",   wr_cnt, 0);
    check("bad_miso",    miso_seen, 0);
    xact(8'h0B, 8'h10, 8'h00, 8'h00, 3, r0, r1, r2, r3);
    check("bad_reg10", r2, 8'h00);

    // Abort after 5 data bits
    clear_mon();
    cs_begin();
    xfer_bits(8'h0A, 8, r0);
    xfer_bits(8'h10, 8, r1);
    xfer_bits(8'hFF, 5, r2);
    cs_end();
    check("abort_no_wr", wr_cnt, 0);
    check("abort_busy",  busy, 0);
    xact(8'h0B, 8'h10, 8'h00, 8'h00, 3, r0, r1, r2, r3);
    check("abort_reg10", r2, 8'h00);
    xact(8'h0A, 8'h10, 8'hC3, 8'h00, 3, r0, r1, r2, r3);
    xact(8'h0B, 8'h10, 8'h00, 8'h00, 3, r0, r1, r2, r3);
    check("post_abort_rd", r2, 8'hC3);

    // Reset in the middle of a read's first data byte
    xact(8'h0A, 8'h11, 8'h99, 8'h00, 3, r0, r1, r2, r3);
    cs_begin();
    xfer_bits(8'h0B, 8, r0);
    xfer_bits(8'h11, 8, r1);
    xfer_bits(8'h00, 3, r2);
    check("pre_rst_bits", r2, 8'h80);   // 0x99 MSB first: 1,0,0
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_miso", miso, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_addr", wr_addr, 0);
    check("mid_rst_wr_data", wr_data, 0);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
    clear_mon();
    xfer_bits(8'h0A, 8, r0);
    xfer_bits(8'h12, 8, r1);
    xfer_bits(8'h44, 8, r2);
    check("post_rst_busy",  busy, 0);
    check("post_rst_no_wr", wr_cnt, 0);
    check("post_rst_no_err", err_cnt, 0);
    check("post_rst_miso",  miso_seen, 0);
    cs_end();
    xact(8'h0B, 8'h11, 8'h00, 8'h00, 4, r0, r1, r2, r3);
    check("rst_cleared_11", r2, 8'h00);
    check("rst_not_written_12", r3, 8'h00);
    xact(8'h0B, 8'h2D, 8'h00, 8'h00, 3, r0, r1, r2, r3);
    check("rst_cleared_2d", r2, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
